// File: rtl/alu_md_pkg.sv
// Shared opcode constants, default width and control-state encoding for the
// execute-stage ALU and multiply/divide unit.
package alu_md_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_NOR  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/alu_md_core.sv
// Width-generic combinational ALU: result c and signed overflow flag for add/sub.
module alu_core
  import alu_md_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] c,
  output logic             over
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign shamt = a[SH_W-1:0];
  assign sum   = a + b;
  assign diff  = a - b;

  always_comb begin
    c    = '0;
    over = 1'b0;
    case (op)
      ALU_ADD: begin
        c    = sum;
        // Overflow when both operands share a sign the result does not.
        over = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        c    = diff;
        over = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      ALU_OR:   c = a | b;
      ALU_AND:  c = a & b;
      ALU_XOR:  c = a ^ b;
      ALU_SLL:  c = b << shamt;
      ALU_SRL:  c = b >> shamt;
      ALU_SRA:  c = $signed(b) >>> shamt;
      ALU_NOR:  c = ~(a | b);
      ALU_SLT:  c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: c = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_LUI:  c = b << (WIDTH / 2);
      default:  c = '0;
    endcase
  end

endmodule

// File: rtl/alu_md.sv
// Execute-stage arithmetic: combinational ALU plus an iterative multiply/divide
// unit owning HI/LO, with busy held for a fixed per-operation latency.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] c,
  output logic             over,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MSB     = WIDTH - 1;
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a    (a),
    .b    (b),
    .op   (op),
    .c    (c),
    .over (over)
  );

  // Handshake: md_start is a single-cycle request, taken at the rising edge only
  // when busy is 0; a request seen while busy is 1 is dropped, never queued.
  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, load, commit;
  logic [WIDTH-1:0] ra, rb;
  logic [2:0]       rop;

  assign accept = md_start && (state == MD_IDLE);
  assign busy   = (state == MD_RUN);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    commit    = 1'b0;
    case (state)
      MD_IDLE: begin
        if (accept && !md_op[2]) begin
          load      = 1'b1;
          state_nxt = MD_RUN;
          cnt_nxt   = md_op[1] ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_RUN: begin
        if (cnt == '0) begin
          commit    = 1'b1;
          state_nxt = MD_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  // One shared multiplier; sign extension is applied only for signed mult.
  logic                   msgn;
  logic [2*WIDTH-1:0]     ea, eb, prod;
  logic                   div_zero, div_ovf;
  logic [WIDTH-1:0]       safe_b, q_u, r_u;
  logic signed [WIDTH-1:0] q_s, r_s;
  logic [WIDTH-1:0]       res_hi, res_lo;

  assign msgn = (rop == MD_MULT);
  assign ea   = {{WIDTH{msgn & ra[MSB]}}, ra};
  assign eb   = {{WIDTH{msgn & rb[MSB]}}, rb};
  assign prod = ea * eb;

  // Dividing by 1 in the zero and most-negative/-1 cases keeps the divider
  // well-defined and already yields lo = a, hi = 0 for the overflow case.
  assign div_zero = (rb == '0);
  assign div_ovf  = (rop == MD_DIV) && (ra == {1'b1, {(WIDTH-1){1'b0}}}) && (rb == '1);
  assign safe_b   = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : rb;
  assign q_s      = $signed(ra) / $signed(safe_b);
  assign r_s      = $signed(ra) % $signed(safe_b);
  assign q_u      = ra / safe_b;
  assign r_u      = ra % safe_b;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (rop)
      MD_MULT, MD_MULTU: {res_hi, res_lo} = prod;
      MD_DIV: begin
        res_hi = div_zero ? ra : r_s;
        res_lo = div_zero ? '1 : q_s;
      end
      MD_DIVU: begin
        res_hi = div_zero ? ra : r_u;
        res_lo = div_zero ? '1 : q_u;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      cnt   <= '0;
      ra    <= '0;
      rb    <= '0;
      rop   <= MD_MULT;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        ra  <= a;
        rb  <= b;
        rop <= md_op;
      end
      if (commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (accept && (md_op == MD_MTHI)) begin
        hi <= a;
      end else if (accept && (md_op == MD_MTLO)) begin
        lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: ALU vector table, random ALU and multiply/divide
// traffic against an arithmetic reference model, and hand-written timing corners.
module tb_alu_md;

  localparam int W      = 32;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  logic         clk, rst_n;
  logic [W-1:0] a, b, c, hi, lo;
  logic [3:0]   op;
  logic         over, md_start, busy;
  logic [2:0]   md_op;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_hi, m_lo;
  logic         hold_ok, alu_ok;

  alu_md #(.WIDTH(W), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .op       (op),
    .c        (c),
    .over     (over),
    .md_start (md_start),
    .md_op    (md_op),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  // clock / global time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference models
  function automatic void alu_ref(input logic [3:0] o, input logic [W-1:0] x, y,
                                  output logic [W-1:0] r, output logic v);
    longint sx, sy, s;
    int unsigned sh;
    logic [W-1:0] fill;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = x[4:0];
    r = '0;
    v = 1'b0;
    case (o)
      4'd0: begin s = sx + sy; r = s[W-1:0]; v = (s > SMAX) || (s < SMIN); end
      4'd1: begin s = sx - sy; r = s[W-1:0]; v = (s > SMAX) || (s < SMIN); end
      4'd2: r = x | y;
      4'd3: r = x & y;
      4'd4: r = x ^ y;
      4'd5: r = y << sh;
      4'd6: r = y >> sh;
      4'd7: begin
        fill = y[W-1] ? ~({W{1'b1}} >> sh) : '0;
        r = (y >> sh) | fill;
      end
      4'd8: r = ~(x | y);
      4'd9: r = (sx < sy) ? 1 : 0;
      4'd10: r = (x < y) ? 1 : 0;
      4'd11: r = {y[15:0], 16'h0000};
      default: r = '0;
    endcase
  endfunction

  function automatic void md_ref(input logic [2:0] o, input logic [W-1:0] x, y,
                                 input logic [W-1:0] oh, ol,
                                 output logic [W-1:0] h, l);
    longint sx, sy, ux, uy, q, rm;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    h = oh;
    l = ol;
    case (o)
      3'd0: begin p = sx * sy; {h, l} = p; end
      3'd1: begin p = ux * uy; {h, l} = p; end
      3'd2, 3'd3: begin
        if (y == 0) begin
          l = '1;
          h = x;
        end else begin
          q  = (o == 3'd2) ? sx / sy : ux / uy;
          rm = (o == 3'd2) ? sx - q * sy : ux - q * uy;
          l  = q[W-1:0];
          h  = rm[W-1:0];
        end
      end
      3'd4: h = x;
      3'd5: l = x;
      default: ;
    endcase
  endfunction

  // drivers (called and returning just after a falling edge)
  task automatic start_md(input logic [2:0] o, input logic [W-1:0] x, y);
    md_op = o;
    a = x;
    b = y;
    md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    a = $urandom;
    b = $urandom;
    md_op = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_idle(output int cyc);
    logic [W-1:0] er;
    logic ev;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      #1;
      alu_ref(op, a, b, er, ev);
      if (c !== er || over !== ev) alu_ok = 1'b0;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_arith(input string nm, input logic [2:0] o, input logic [W-1:0] x, y);
    logic [W-1:0] eh, el;
    int cyc;
    md_ref(o, x, y, m_hi, m_lo, eh, el);
    exp_q.push_back(eh);
    exp_q.push_back(el);
    hold_ok = 1'b1;
    alu_ok  = 1'b1;
    start_md(o, x, y);
    wait_idle(cyc);
    check({nm, "_busy_cycles"}, 64'(cyc), 64'(o[1] ? DIV_N : MULT_N));
    check({nm, "_hold"}, 64'(hold_ok), 64'd1);
    check({nm, "_alu_while_busy"}, 64'(alu_ok), 64'd1);
    eh = exp_q.pop_front();
    el = exp_q.pop_front();
    check({nm, "_hi"}, 64'(hi), 64'(eh));
    check({nm, "_lo"}, 64'(lo), 64'(el));
    m_hi = hi;
    m_lo = lo;
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         over;
  } alu_vec_t;

  alu_vec_t tab[18];

  initial begin
    logic [W-1:0] er, eh, el, x, y;
    logic ev, still_ok;
    logic [2:0] o;
    int cyc;

    tab[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    tab[1]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    tab[2]  = '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    tab[3]  = '{4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0};
    tab[4]  = '{4'd2,  32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0};
    tab[5]  = '{4'd3,  32'h0000F0F0, 32'h00003C3C, 32'h00003030, 1'b0};
    tab[6]  = '{4'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
    tab[7]  = '{4'd5,  32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    tab[8]  = '{4'd5,  32'h00000021, 32'h00000001, 32'h00000002, 1'b0};
    tab[9]  = '{4'd6,  32'h00000004, 32'h80000000, 32'h08000000, 1'b0};
    tab[10] = '{4'd7,  32'h00000004, 32'h80000000, 32'hF8000000, 1'b0};
    tab[11] = '{4'd7,  32'h0000001F, 32'h80000001, 32'hFFFFFFFF, 1'b0};
    tab[12] = '{4'd8,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    tab[13] = '{4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    tab[14] = '{4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    tab[15] = '{4'd11, 32'h00000000, 32'h00001234, 32'h12340000, 1'b0};
    tab[16] = '{4'd12, 32'h00000001, 32'h00000002, 32'h00000000, 1'b0};
    tab[17] = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};

    // reset
    rst_n = 1'b0;
    md_start = 1'b0;
    md_op = 3'd0;
    op = 4'd0;
    a = '0;
    b = '0;
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU vector table
    for (int i = 0; i < 18; i++) begin
      op = tab[i].op;
      a = tab[i].a;
      b = tab[i].b;
      #1;
      check($sformatf("alu_tab%0d_c", i), 64'(c), 64'(tab[i].c));
      check($sformatf("alu_tab%0d_over", i), 64'(over), 64'(tab[i].over));
    end
    @(negedge clk);

    // random ALU against model
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 1) == 1, 31'h7FFFFFFF ^ 31'($urandom_range(0, 3))} : $urandom;
      #1;
      alu_ref(op, a, b, er, ev);
      check("alu_rand_c", 64'(c), 64'(er));
      check("alu_rand_over", 64'(over), 64'(ev));
      @(negedge clk);
    end

    // directed multiply/divide
    run_arith("mult_neg3x7", 3'd0, 32'hFFFFFFFD, 32'h00000007);
    run_arith("multu_max_x2", 3'd1, 32'hFFFFFFFF, 32'h00000002);
    run_arith("div_neg7_2", 3'd2, 32'hFFFFFFF9, 32'h00000002);
    run_arith("divu_by_zero", 3'd3, 32'h00000007, 32'h00000000);
    run_arith("div_minneg_m1", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_arith("div_by_zero", 3'd2, 32'hFFFFFF00, 32'h00000000);

    // mtlo while busy is dropped; the same request in the first idle cycle lands
    hold_ok = 1'b1;
    alu_ok  = 1'b1;
    start_md(3'd2, 32'd100, 32'd7);
    start_md(3'd5, 32'h00001234, 32'h0);
    wait_idle(cyc);
    check("ignored_start_cycles", 64'(cyc), 64'(DIV_N - 1));
    check("ignored_mtlo_lo", 64'(lo), 64'd14);
    check("ignored_mtlo_hi", 64'(hi), 64'd2);
    m_hi = hi;
    m_lo = lo;
    start_md(3'd5, 32'h00001234, 32'h0);
    check("mtlo_after_fall_lo", 64'(lo), 64'h1234);
    check("mtlo_after_fall_hi", 64'(hi), 64'd2);
    check("mtlo_after_fall_busy", 64'(busy), 64'd0);
    m_lo = lo;

    // asynchronous reset in the third cycle of a divide
    start_md(3'd2, 32'd50, 32'd3);
    repeat (2) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_hi", 64'(hi), 64'd0);
    check("async_reset_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    still_ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== '0 || lo !== '0) still_ok = 1'b0;
    end
    check("no_commit_after_reset", 64'(still_ok), 64'd1);

    // back-to-back: mult then mthi in the first idle cycle
    run_arith("b2b_mult", 3'd0, 32'h00012345, 32'hFFFF0003);
    start_md(3'd4, 32'hCAFEF00D, 32'h0);
    check("b2b_mthi_hi", 64'(hi), 64'hCAFEF00D);
    check("b2b_mthi_lo", 64'(lo), 64'(m_lo));
    check("b2b_mthi_busy", 64'(busy), 64'd0);
    m_hi = hi;

    // random multiply/divide traffic
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'h0 :
          (($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom);
      if (o <= 3'd3) begin
        run_arith($sformatf("rand%0d_op%0d", i, o), o, x, y);
      end else begin
        md_ref(o, x, y, m_hi, m_lo, eh, el);
        start_md(o, x, y);
        check("rand_move_hi", 64'(hi), 64'(eh));
        check("rand_move_lo", 64'(lo), 64'(el));
        check("rand_move_busy", 64'(busy), 64'd0);
        m_hi = eh;
        m_lo = el;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised execute-stage arithmetic block for the pipelined MIPS core.
- Combines a width-generic combinational ALU with an iterative multiply/divide unit that owns the HI/LO registers.
- The pipeline stalls on `busy` while the multiply/divide unit is running.
- This generation adds: width parameter, signed/unsigned compare, a defined overflow flag, `lui`, and mult/div with configurable latency.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two, at least 8.
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu; at least 1.
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu; at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- a  in  WIDTH  operand A; supplies the shift amount for shift ops.
- b  in  WIDTH  operand B; the value shifted for shift ops.
- op  in  4  ALU operation select.
- c  out  WIDTH  ALU result; combinational.
- over  out  1  signed overflow flag for add/sub; combinational.
- md_start  in  1  one-cycle request to the multiply/divide unit.
- md_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 do nothing.
- busy  out  1  multiply/divide unit occupied; registered.
- hi  out  WIDTH  HI register; registered.
- lo  out  WIDTH  LO register; registered.

Behaviour:
- Reset: asynchronous, active-low, one clock. When `rst_n` is low: `busy` = 0, `hi` = 0, `lo` = 0, iteration counter = 0, and any pending result is discarded. This applies mid-operation as well; the operation does not resume after reset.
- ALU opcode map (combinational, zero latency):
  - 0 add: a+b
  - 1 sub: a-b
  - 2 or
  - 3 and
  - 4 xor
  - 5 sll: b << a[log2(WIDTH)-1:0]
  - 6 srl: logical right shift, same shift amount
  - 7 sra: arithmetic right shift, same shift amount
  - 8 nor
  - 9 slt: 1 if a < b signed, else 0
  - 10 sltu: 1 if a < b unsigned, else 0
  - 11 lui: b << (WIDTH/2)
  - 12-15: c = 0
- ALU arithmetic rules:
  - add/sub results wrap modulo 2^WIDTH.
  - over = 1 only for op 0/1 with signed overflow; for all other ops over = 0.
  - Shift amount 0 returns b unchanged.
  - sra by WIDTH-1 on a negative b yields all ones.
- md_start is accepted only when busy = 0. A md_start while busy = 1 is ignored; it is not queued and hi/lo are untouched.
- mthi/mtlo:
  - Accepted start writes `a` to hi (mthi) or lo (mtlo) at that clock edge.
  - busy stays 0.
- mult/multu/div/divu:
  - Accepted start captures a, b and md_op.
  - busy goes 1 on the next cycle and stays 1 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - hi/lo update on the same edge at which busy falls.
  - A new md_start is accepted in the first cycle busy = 0 (back-to-back allowed).
  - hi/lo hold their old values while busy.
- Results:
  - mult/multu: {hi,lo} = full 2*WIDTH product, signed or unsigned respectively.
  - div/divu: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - Divide by zero (div or divu): lo = all ones, hi = a; duration is unchanged.
  - div with a = most-negative value and b = -1: lo = a, hi = 0.
- Operand stability: a, b and md_op may change after the start cycle without affecting the running operation.
- ALU ops are independent of busy; c and over remain valid while busy = 1.
- Control FSM: states IDLE and RUN.
  - IDLE→RUN on an accepted arithmetic start; counter loaded with N-1.
  - RUN decrements the counter each cycle. At 0 it commits hi/lo and returns to IDLE.
  - busy = (state == RUN).

Decomposition:
- Shared package holds:
  - ALU opcode constants (ALU_ADD … ALU_LUI).
  - MD opcode constants (MD_MULT … MD_MTLO).
  - Default WIDTH.
- The ALU is the natural sub-module: `alu_core`, purely combinational, producing c and over.
- alu_md instantiates `alu_core` and contains the FSM, counter, operand registers, and HI/LO.
- The product and quotient may be computed combinationally from the registered operands; only the commit timing is sequenced.

Test Plan:
- ALU, WIDTH=32: op=0, a=0x7FFFFFFF, b=1 -> c=0x80000000, over=1. op=9, a=0xFFFFFFFF, b=1 -> c=1. op=10, same operands -> c=0. op=7, a=4, b=0x80000000 -> c=0xF8000000.
- mult, a=-3, b=7, MULT_CYCLES=5 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB. multu, a=0xFFFFFFFF, b=2 -> hi=1, lo=0xFFFFFFFE.
- div, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu, a=7, b=0 -> lo=0xFFFFFFFF, hi=7. div, a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- md_start mtlo with a=0x1234 while busy=1 -> ignored, lo unchanged. Same request in the cycle busy falls -> lo=0x1234 one edge later, busy stays 0.
- Reset: assert rst_n=0 in the third cycle of a div -> busy, hi, lo = 0 immediately (asynchronous). After release, no commit occurs.
- Back-to-back: mult, then mthi issued in the first cycle busy=0 -> product committed, then hi overwritten with the new a on the following edge.
